// File: rtl/srli_operation_unit.sv
// srli_operation_unit: logical right-shift-immediate (SRLI) execute unit.
// Shifts SrcA right by the low log2(DATA_WIDTH) bits of Immediate and
// fills the vacated MSBs with zeros. The result is registered, so the
// latency is one cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears Rd and out_valid)
//   in_valid   SrcA/Immediate carry an operation this cycle
//   SrcA       rs1 operand
//   Immediate  decoded I-type immediate (only the shamt bits are used)
//   Rd         registered shift result; held while in_valid=0
//   out_valid  Rd carries the result of the previous cycle's valid op

// One barrel-shifter stage: shift right by SHIFT when en, else pass through.
module srli_shift_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT      = 1
) (
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  assign dout = en ? (din >> SHIFT) : din;
endmodule

module srli_operation_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] Immediate,
  output logic [DATA_WIDTH-1:0] Rd,
  output logic                  out_valid
);
  localparam int SHW = $clog2(DATA_WIDTH);
  // Opcode width is shared with sibling ALU blocks but has no effect here.
  localparam int unused_opcode_len = OPCODE_LENGTH;

  logic [SHW-1:0] shamt;
  // funct7 / sign-extension bits of the immediate are deliberately ignored.
  logic           unused_imm_hi;

  assign shamt         = Immediate[SHW-1:0];
  assign unused_imm_hi = ^Immediate[DATA_WIDTH-1:SHW];

  // stage_val[0] is the operand; stage_val[k+1] has applied shamt[k].
  logic [SHW:0][DATA_WIDTH-1:0] stage_val;
  assign stage_val[0] = SrcA;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    srli_shift_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .SHIFT     (1 << k)
    ) u_stage (
      .en  (shamt[k]),
      .din (stage_val[k]),
      .dout(stage_val[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Rd        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Rd <= stage_val[SHW];
    end
  end
endmodule

// File: tb/tb_srli_operation_unit.sv
module tb_srli_operation_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] Immediate = '0;
  logic [31:0] Rd;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  srli_operation_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .SrcA(SrcA),
    .Immediate(Immediate), .Rd(Rd), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: the architectural SRLI result and valid tag.
  logic [31:0] m_rd;
  logic        m_vld;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd  <= 32'h0;
      m_vld <= 1'b0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) m_rd <= SrcA >> Immediate[4:0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      checks++;
      if (out_valid !== m_vld || Rd !== m_rd) begin
        errors++;
        $display("FAIL model_cmp t=%0t got Rd=%h v=%b want Rd=%h v=%b",
                 $time, Rd, out_valid, m_rd, m_vld);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] exp_rd,
                       input logic exp_v);
    checks++;
    if (Rd !== exp_rd || out_valid !== exp_v) begin
      errors++;
      $display("FAIL %s got Rd=%h v=%b want Rd=%h v=%b",
               name, Rd, out_valid, exp_rd, exp_v);
    end
  endtask

  // Drive one cycle of inputs and check the hand-computed result after the edge.
  task automatic apply(input string name, input logic [31:0] a,
                       input logic [31:0] imm, input logic v,
                       input logic [31:0] exp_rd, input logic exp_v);
    @(negedge clk);
    SrcA = a; Immediate = imm; in_valid = v;
    @(posedge clk); #1;
    check(name, exp_rd, exp_v);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset_state", 32'h0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    cmp_en = 1'b1;

    apply("basic_16_by_2",  32'h00000010, 32'h00000002, 1'b1, 32'h00000004, 1'b1);
    apply("one_by_1",       32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 1'b1);
    apply("zero_fill",      32'hFFFFFFFF, 32'h00000004, 1'b1, 32'h0FFFFFFF, 1'b1);
    apply("shamt_0",        32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b1);
    apply("shamt_31",       32'h80000000, 32'h0000001F, 1'b1, 32'h00000001, 1'b1);
    apply("imm_upper_ign",  32'h80000000, 32'hFFFFFFE3, 1'b1, 32'h10000000, 1'b1);

    // Streaming, then idle with junk operands: Rd must hold.
    apply("stream_0",       32'hF0F0F0F0, 32'h00000008, 1'b1, 32'h00F0F0F0, 1'b1);
    apply("stream_1",       32'h12345678, 32'h00000010, 1'b1, 32'h00001234, 1'b1);
    apply("stream_2",       32'hA5A5A5A5, 32'h00000021, 1'b1, 32'h52D2D2D2, 1'b1);
    apply("idle_hold",      32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h52D2D2D2, 1'b0);
    apply("idle_hold2",     32'h00000000, 32'h00000005, 1'b0, 32'h52D2D2D2, 1'b0);

    // Sweep every shift amount on a pattern with both end bits set.
    for (int s = 0; s < 32; s++) begin
      logic [31:0] pat;
      pat = 32'h80000001;
      apply("sweep", pat, 32'(s) | 32'hFFFFFF00, 1'b1, pat >> s, 1'b1);
    end

    // Asynchronous reset between edges while out_valid=1.
    apply("pre_reset",      32'hFFFF0000, 32'h0000000C, 1'b1, 32'h000FFFF0, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; SrcA = 32'hCAFEF00D; Immediate = 32'h1;
    @(posedge clk); #1 check("post_release_idle", 32'h0, 1'b0);
    @(posedge clk); #1 check("post_release_idle2", 32'h0, 1'b0);
    apply("first_after_rst", 32'h00000100, 32'hFFFFF808, 1'b1, 32'h00000001, 1'b1);
    apply("final_idle",     32'h00000000, 32'h00000000, 1'b0, 32'h00000001, 1'b0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/srli_operation_unit.md
# srli_operation_unit

Logical right-shift-immediate execution unit for the RISC-V datapath, implementing SRLI. It shifts a register operand right by the shift amount held in the low bits of the decoded immediate and zero-fills from the MSB side. The result is registered, so it sits in the ALU/execute stage with one cycle of latency and a simple valid tag.

## Interface

Parameters:
- DATA_WIDTH, 32: operand and result width; must be a power of two ≥ 2.
- OPCODE_LENGTH, 4: ALU opcode width shared with sibling ALU blocks; reserved here, no functional effect.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  SrcA/Immediate hold a valid operation this cycle.
- SrcA  input  DATA_WIDTH  rs1 operand value.
- Immediate  input  DATA_WIDTH  sign-extended I-type immediate; only shamt bits are used.
- Rd  output  DATA_WIDTH  registered shift result.
- out_valid  output  1  Rd holds the result of an in_valid operation.

## Operation

- SHW = log2(DATA_WIDTH); shamt = Immediate[SHW-1:0] (5 bits at width 32). Immediate[DATA_WIDTH-1:SHW] are ignored, including funct7-style bits and sign-extension bits.
- result = SrcA >> shamt, logical. The vacated upper shamt bits are 0. The sign bit of SrcA is never replicated.
- shamt = 0 gives result = SrcA. shamt = DATA_WIDTH-1 gives result = {0…0, SrcA[DATA_WIDTH-1]}.
- The shifter is a log2 barrel shifter with SHW stages. Stage k shifts by 2^k when shamt[k]=1 and passes the value through otherwise. The stages are combinational and there are no multi-cycle shifts.
- On each rising clk edge:
  - Rd ← result when in_valid=1. Rd holds its value when in_valid=0.
  - out_valid ← in_valid.
- There is no backpressure. A new operation may be presented every cycle and is never stalled or dropped.
- The unit has no state machine. Its only state is the Rd and out_valid registers.

## Timing

- Latency is 1 cycle. Operands sampled at edge N appear on Rd with out_valid=1 after edge N, and stay valid until the next edge.
- Throughput is one result per cycle.
- Reset values: Rd = 0 and out_valid = 0, both asserted immediately when rst_n falls, without waiting for clk.
- Reset mid-operation discards any in-flight result. The first valid result after reset release comes from the first edge at which in_valid=1 with rst_n=1.
- Back-to-back valid inputs produce back-to-back results, each reflecting only its own operands.
- An in_valid=0 cycle clears out_valid on the next edge and leaves Rd unchanged.
- There is no combinational path from inputs to outputs.

## Test plan

- SrcA=0x00000010, Immediate=0x00000002, in_valid=1 → one edge later Rd=0x00000004, out_valid=1.
- SrcA=0x00000001, Immediate=0x00000001 → Rd=0x00000000.
- SrcA=0xFFFFFFFF, Immediate=0x00000004 → Rd=0x0FFFFFFF (zero-fill, not sign-fill).
- Shamt boundaries:
  - SrcA=0xDEADBEEF, Immediate=0 → Rd=0xDEADBEEF.
  - SrcA=0x80000000, Immediate=31 → Rd=0x00000001.
  - Immediate=0xFFFFFFE3 (shamt 3) on SrcA=0x80000000 → Rd=0x10000000 (upper bits ignored).
- Streaming: three consecutive valid ops, then in_valid=0 → Rd updates every cycle and then holds its last value with out_valid=0.
- Assert rst_n=0 between clock edges while out_valid=1 → Rd=0 and out_valid=0 immediately. After release with in_valid=0 both stay 0.
